// File: rtl/ahb_sram_arbiter.sv
// Two-requester round-robin arbiter that sequences one AHB-Lite SINGLE
// transfer at a time toward an SRAM slave and returns status to the winner.
`timescale 1ns/1ps
module ahb_sram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_write,
  input  logic [5:0]      req_size,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      req_ready,
  output logic [1:0]      rsp_valid,
  output logic            rsp_err,
  output logic [DW-1:0]   rsp_rdata,
  output logic            HSEL,
  output logic [AW-1:0]   HADDR,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic [DW-1:0]   HWDATA,
  output logic            HREADY,
  input  logic [DW-1:0]   HRDATA,
  input  logic            HREADYOUT,
  input  logic            HRESP
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DW/8));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_gnt;
  logic              r_write;
  logic [2:0]        r_size;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW-1:0]     r_rdata;
  logic              r_err;

  logic              w_gnt_id;
  logic              w_accept;
  logic              w_legal;
  logic              w_sel_write;
  logic [2:0]        w_sel_size;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_wdata;
  logic [AW-1:0]     w_align_mask;

  // On a tie the requester not granted last time wins
  always_comb begin
    w_gnt_id = 1'b0;
    case (req_valid)
      2'b10:   w_gnt_id = 1'b1;
      2'b11:   w_gnt_id = ~r_last;
      default: w_gnt_id = 1'b0;
    endcase
  end

  assign w_accept     = (r_state == S_IDLE) && (|req_valid);
  assign w_sel_write  = w_gnt_id ? req_write[1]          : req_write[0];
  assign w_sel_size   = w_gnt_id ? req_size[5:3]         : req_size[2:0];
  assign w_sel_addr   = w_gnt_id ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
  assign w_sel_wdata  = w_gnt_id ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];
  assign w_align_mask = (AW'(1) << w_sel_size) - AW'(1);
  assign w_legal      = (w_sel_size <= MAX_SIZE) && ((w_sel_addr & w_align_mask) == '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_legal ? S_ADDR : S_RESP;
      S_ADDR:  if (HREADYOUT) w_next = S_DATA;
      S_DATA:  if (HREADYOUT) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // req_ready is gated by reset so no accept is advertised while held in reset
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    HSEL      = 1'b0;
    HTRANS    = 2'b00;
    case (r_state)
      S_IDLE: if (HRESETn && (|req_valid)) req_ready = w_gnt_id ? 2'b10 : 2'b01;
      S_ADDR: begin
        HSEL   = 1'b1;
        HTRANS = 2'b10;
      end
      S_RESP:  rsp_valid = r_gnt ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last  <= w_gnt_id;
        r_gnt   <= w_gnt_id;
        r_write <= w_sel_write;
        r_size  <= w_sel_size;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        if (!w_legal) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if ((r_state == S_DATA) && HREADYOUT) begin
        r_rdata <= r_write ? '0 : HRDATA;
        r_err   <= HRESP;
      end
    end
  end

  assign HADDR     = r_addr;
  assign HWRITE    = r_write;
  assign HSIZE     = r_size;
  assign HWDATA    = r_wdata;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HREADY    = HREADYOUT;
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Randomized scoreboard bench for ahb_sram_arbiter with a behavioural SRAM
// slave and a transaction-level reference model.
`timescale 1ns/1ps
module tb_ahb_sram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [5:0]      req_size = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic            HSEL;
  logic [AW-1:0]   HADDR;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic [DW-1:0]   HWDATA;
  logic            HREADY;
  logic [DW-1:0]   HRDATA;
  logic            HREADYOUT;
  logic            HRESP;

  ahb_sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          id;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          exp_cyc;
  } exp_t;

  typedef struct {
    int waits;
    bit err;
  } plan_t;

  exp_t        exp_q[$];
  plan_t       plan_q[$];
  int          acc_log[$];
  logic [31:0] slv_mem[16];
  logic [31:0] ref_mem[16];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int force_waits = -1;
  int force_err = -1;
  int ref_last = 1;
  int acc_cnt[2] = '{0, 0};
  int rsp_cnt[2] = '{0, 0};

  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [2:0]  cur_size = '0;
  bit          cur_write = 1'b0;
  bit          cur_legal = 1'b0;
  int          cur_acc_cyc = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;

  bit          s_active;
  int          s_cnt;
  bit          s_err;
  bit          s_wr;
  logic [31:0] s_addr;
  logic [2:0]  s_size;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw,
                                        logic [2:0] sz, logic [31:0] a);
    logic [31:0] m;
    case (sz)
      3'd0:    m = 32'h0000_00FF << (8 * a[1:0]);
      3'd1:    m = 32'h0000_FFFF << (16 * a[1]);
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | (nw & m);
  endfunction

  // Reference model: round-robin grant, legality and expected response per accept
  function automatic void accept_cmd();
    exp_t        x;
    plan_t       p;
    int          eid;
    int          gid;
    int          lat;
    logic [1:0]  acc;
    acc = req_valid & req_ready;
    eid = (req_valid == 2'b11) ? 1 - ref_last : (req_valid[1] ? 1 : 0);
    gid = acc[1] ? 1 : 0;
    check("grant_id", 64'(gid), 64'(eid));
    check("ready_onehot", 64'(acc), 64'((eid == 1) ? 2'b10 : 2'b01));
    ref_last = eid;
    x.id    = eid;
    x.wr    = req_write[eid];
    x.size  = req_size[3*eid +: 3];
    x.addr  = req_addr[32*eid +: 32];
    x.wdata = req_wdata[32*eid +: 32];
    if ((x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0)) begin
      x.err   = 1'b1;
      x.rdata = '0;
      lat     = 1;
      cur_legal = 1'b0;
    end else begin
      p.err   = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 99) < 10);
      p.waits = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
      plan_q.push_back(p);
      x.err   = p.err;
      x.rdata = x.wr ? 32'h0 : ref_mem[x.addr[5:2]];
      lat     = p.err ? 4 : 3 + p.waits;
      cur_legal = 1'b1;
    end
    x.exp_cyc   = cyc + lat;
    cur_addr    = x.addr;
    cur_wdata   = x.wdata;
    cur_size    = x.size;
    cur_write   = x.wr;
    cur_acc_cyc = cyc;
    exp_q.push_back(x);
    acc_cnt[eid]++;
    acc_log.push_back(eid);
  endfunction

  function automatic void bus_check();
    if (HTRANS != 2'b00 && HTRANS != 2'b10) begin
      n_checks++;
      n_fail++;
      $display("FAIL htrans_legal: actual %b required 00 or 10", HTRANS);
    end
    if (HTRANS == 2'b10) begin
      check("nonseq_cycle", 64'(cyc), 64'(cur_acc_cyc + 1));
      check("nonseq_legal_cmd", 64'(cur_legal), 64'(1));
      check("nonseq_hsel", 64'(HSEL), 64'(1));
      check("nonseq_haddr", 64'(HADDR), 64'(cur_addr));
      check("nonseq_hwrite", 64'(HWRITE), 64'(cur_write));
      check("nonseq_hsize", 64'(HSIZE), 64'(cur_size));
      check("hburst", 64'(HBURST), 64'(3'b000));
      check("hprot", 64'(HPROT), 64'(4'b0011));
    end
    if (s_active) begin
      check("data_htrans_idle", 64'(HTRANS), 64'(2'b00));
      check("data_haddr_stable", 64'(HADDR), 64'(cur_addr));
      check("hready_follows", 64'(HREADY), 64'(HREADYOUT));
      if (cur_write) check("data_hwdata", 64'(HWDATA), 64'(cur_wdata));
    end
  endfunction

  function automatic void rsp_check();
    exp_t x;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_unexpected: rsp_valid=%b with no outstanding command (cycle %0d)", rsp_valid, cyc);
      return;
    end
    x = exp_q.pop_front();
    check("rsp_id", 64'(rsp_valid), 64'((x.id == 1) ? 2'b10 : 2'b01));
    check("rsp_err", 64'(rsp_err), 64'(x.err));
    check("rsp_rdata", 64'(rsp_rdata), 64'(x.rdata));
    check("rsp_cycle", 64'(cyc), 64'(x.exp_cyc));
    if (x.wr && !x.err) ref_mem[x.addr[5:2]] = merge(ref_mem[x.addr[5:2]], x.wdata, x.size, x.addr);
    rsp_cnt[x.id]++;
    last_err   = rsp_err;
    last_rdata = rsp_rdata;
  endfunction

  initial begin
    forever begin
      @(posedge HCLK);
      if (HRESETn && ((req_valid & req_ready) != 2'b00)) accept_cmd();
    end
  end

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        bus_check();
        if (rsp_valid != 2'b00) rsp_check();
      end
    end
  end

  // SRAM slave: wait states and two-cycle ERROR taken from the plan queue
  initial begin
    plan_t p;
    int    cnt;
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) begin
        s_active  <= 1'b0;
        s_cnt     <= 0;
        s_err     <= 1'b0;
        s_wr      <= 1'b0;
        s_addr    <= '0;
        s_size    <= '0;
        HREADYOUT <= 1'b1;
        HRESP     <= 1'b0;
        HRDATA    <= '0;
      end else if (s_active) begin
        if (HREADYOUT) begin
          if (s_wr && !s_err) slv_mem[s_addr[5:2]] <= merge(slv_mem[s_addr[5:2]], HWDATA, s_size, s_addr);
          s_active  <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          HRDATA    <= $urandom;
        end else begin
          s_cnt     <= s_cnt - 1;
          HREADYOUT <= (s_cnt == 1);
          HRDATA    <= (s_cnt == 1) ? slv_mem[s_addr[5:2]] : $urandom;
        end
      end else if (HSEL && HTRANS == 2'b10 && HREADY) begin
        if (plan_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_transfer_unplanned: NONSEQ to 0x%0h with no legal command", HADDR);
          p.err   = 1'b0;
          p.waits = 0;
        end else begin
          p = plan_q.pop_front();
        end
        cnt = p.err ? 1 : p.waits;
        s_active  <= 1'b1;
        s_wr      <= HWRITE;
        s_addr    <= HADDR;
        s_size    <= HSIZE;
        s_err     <= p.err;
        s_cnt     <= cnt;
        HREADYOUT <= (cnt == 0);
        HRESP     <= p.err;
        HRDATA    <= (cnt == 0) ? slv_mem[HADDR[5:2]] : $urandom;
      end
    end
  end

  task automatic drive(int id, bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    req_write[id]       = wr;
    req_size[3*id +: 3] = sz;
    req_addr[32*id +: 32]  = a;
    req_wdata[32*id +: 32] = wd;
    req_valid[id]       = 1'b1;
  endtask

  task automatic issue(int id, bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    int start;
    start = acc_cnt[id];
    drive(id, wr, sz, a, wd);
    for (int k = 0; k < 300 && acc_cnt[id] == start; k++) @(negedge HCLK);
    check("accepted", 64'(acc_cnt[id] - start), 64'(1));
    req_valid[id] = 1'b0;
  endtask

  task automatic rand_issue(int id);
    logic [2:0]  sz;
    logic [31:0] a;
    int          word;
    word = $urandom_range(0, 15);
    if ($urandom_range(0, 99) < 8) begin
      if ($urandom_range(0, 1) == 1) begin
        sz = 3'($urandom_range(3, 7));
        a  = 32'(word * 4);
      end else begin
        sz = 3'($urandom_range(1, 2));
        a  = 32'(word * 4 + ((sz == 3'd1) ? 1 + 2 * $urandom_range(0, 1) : $urandom_range(1, 3)));
      end
    end else begin
      sz = 3'($urandom_range(0, 2));
      a  = 32'(word * 4 + (($urandom_range(0, 3) >> sz) << sz));
    end
    repeat ($urandom_range(0, 3)) @(negedge HCLK);
    issue(id, 1'($urandom_range(0, 1)), sz, a, $urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge HCLK);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    @(negedge HCLK);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_hsel"}, 64'(HSEL), 64'(0));
    check({tag, "_htrans"}, 64'(HTRANS), 64'(0));
    check({tag, "_hwrite"}, 64'(HWRITE), 64'(0));
    check({tag, "_haddr"}, 64'(HADDR), 64'(0));
    check({tag, "_hsize"}, 64'(HSIZE), 64'(0));
    check({tag, "_hwdata"}, 64'(HWDATA), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int r1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      slv_mem[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(negedge HCLK);
    check_outputs_zero("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Round-robin with both requesters held valid, 4 reads each
    force_waits = 0;
    force_err   = 0;
    r0 = rsp_cnt[0];
    r1 = rsp_cnt[1];
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 3'd2, 32'(4 * i), 32'h0);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 3'd2, 32'(32 + 4 * i), 32'h0);
      end
    join
    drain();
    check("rr_count0", 64'(rsp_cnt[0] - r0), 64'(4));
    check("rr_count1", 64'(rsp_cnt[1] - r1), 64'(4));
    for (int i = 0; i < 8; i++)
      check("rr_order", 64'((i < acc_log.size()) ? acc_log[i] : -1), 64'(i % 2));

    // Word write then read back
    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    drain();
    check("wr_err", 64'(last_err), 64'(0));
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0);
    drain();
    check("rd_back", 64'(last_rdata), 64'(32'hDEAD_BEEF));

    // Two slave wait states on a read
    force_waits = 2;
    issue(1, 1'b0, 3'd2, 32'h10, 32'h0);
    drain();
    check("wait_rdata", 64'(last_rdata), 64'(32'hDEAD_BEEF));
    force_waits = 0;

    // Two-cycle ERROR on a write, then a normal command
    force_err = 1;
    issue(0, 1'b1, 3'd2, 32'h8, 32'h1234_5678);
    drain();
    check("err_flag", 64'(last_err), 64'(1));
    force_err = 0;
    issue(0, 1'b0, 3'd2, 32'h8, 32'h0);
    drain();
    check("err_next_ok", 64'(last_err), 64'(0));

    // Illegal commands never reach the bus
    issue(1, 1'b0, 3'd2, 32'h13, 32'h0);
    drain();
    check("misaligned_err", 64'(last_err), 64'(1));
    issue(1, 1'b0, 3'd3, 32'h10, 32'h0);
    drain();
    check("oversize_err", 64'(last_err), 64'(1));

    // Randomized traffic from both requesters
    force_waits = -1;
    force_err   = -1;
    fork
      begin
        repeat (40) rand_issue(0);
      end
      begin
        repeat (40) rand_issue(1);
      end
    join
    drain();

    // Reset asserted in the data phase of a write
    force_waits = 3;
    force_err   = 0;
    issue(0, 1'b0, 3'd2, 32'h4, 32'h0);
    drain();
    issue(0, 1'b1, 3'd2, 32'h20, 32'hA5A5_5A5A);
    for (int k = 0; k < 20 && !s_active; k++) @(negedge HCLK);
    check("rst_in_data", 64'(s_active), 64'(1));
    drive(0, 1'b0, 3'd2, 32'h0, 32'h0);
    drive(1, 1'b0, 3'd2, 32'h4, 32'h0);
    #2;
    HRESETn = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    exp_q.delete();
    plan_q.delete();
    acc_log.delete();
    ref_last = 1;
    force_waits = 0;
    repeat (3) @(negedge HCLK);
    check_outputs_zero("held_rst");
    HRESETn = 1'b1;
    fork
      issue(0, 1'b0, 3'd2, 32'h0, 32'h0);
      issue(1, 1'b0, 3'd2, 32'h4, 32'h0);
    join
    drain();
    check("post_rst_first_grant", 64'((acc_log.size() > 0) ? acc_log[0] : -1), 64'(0));
    check("post_rst_accepts", 64'(acc_log.size()), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
